cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL expose these parameters:
- SET_COUNT, 64, number of sets; power of two.
- BASE_ADDR, 32'd1024, data-memory base subtracted from the MEM-stage address.
REQ-002 The block SHALL have exactly these ports, clock and reset first:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- MEM_R_EN  input  1  MEM-stage load request.
- MEM_W_EN  input  1  MEM-stage store request.
- ALU_Res  input  32  byte address from MEM stage.
- Val_Rm  input  32  store data.
- out  output  32  load data.
- ready  output  1  request complete; pipeline freezes while low.
- sram_r_en  output  1  read request to SRAM controller.
- sram_w_en  output  1  write request to SRAM controller.
- sram_addr  output  32  address to SRAM controller (ALU_Res passed through).
- sram_wdata  output  32  store data to SRAM controller.
- sram_rdata  input  64  two-word block returned by SRAM controller.
- sram_ready  input  1  SRAM controller done (one-cycle pulse).

Function
REQ-003 The cache SHALL be 2-way set-associative, write-through, no-write-allocate, with SET_COUNT sets and 64-bit (2-word) lines per way.
REQ-004 Address split, with a = ALU_Res - BASE_ADDR: word select a[2]; index a[8:3]; tag a[18:9] (10 bits); a[1:0] ignored.
REQ-005 Per set storage: valid and tag for each way, a 64-bit line for each way, and one LRU bit (0 = way0 least recently used).
REQ-006 Hit on way w: valid[w] is set and tag[w] equals the address tag; both ways never hit at once.
REQ-007 FSM states: IDLE, READ_MISS, WRITE.
REQ-008 IDLE transitions:
- MEM_R_EN with a hit: out is the selected word and ready=1 in the same cycle (combinational); LRU points to the other way at the clock edge; stay in IDLE.
- MEM_R_EN with a miss: go to READ_MISS; ready=0.
- MEM_W_EN: go to WRITE; ready=0.
- MEM_R_EN and MEM_W_EN together: treat as a write.
- No request: ready=1, out=0.
REQ-009 READ_MISS behaviour:
- Hold sram_r_en=1 until sram_ready.
- On the sram_ready cycle: select the fill way (first invalid way, way0 preferred, else the LRU way); write sram_rdata, tag and valid into it; point LRU to the other way; drive out with the selected word of sram_rdata; ready=1; return to IDLE.
REQ-010 WRITE behaviour:
- Hold sram_w_en=1 with sram_wdata=Val_Rm until sram_ready.
- On the sram_ready cycle: if the address hits, replace the addressed word in the hit line and update LRU; no allocation on a miss; ready=1; return to IDLE.
REQ-011 sram_r_en and sram_w_en SHALL never be high together, and both SHALL be 0 in IDLE.
REQ-012 sram_addr and sram_wdata SHALL follow ALU_Res and Val_Rm, which stay stable while ready=0 because the pipeline is frozen.
REQ-013 out SHALL be 0 in every cycle in which ready=0.

Reset
REQ-014 rst high SHALL asynchronously:
- clear all valid bits and LRU bits;
- force the FSM to IDLE, with sram_r_en=0, sram_w_en=0, out=0 and ready=1.
Line and tag contents are don't-care.
REQ-015 Reset asserted during READ_MISS or WRITE SHALL abort the operation with no cache update; a later sram_ready in IDLE SHALL be ignored.

Verification
REQ-016 Cold read miss:
- Stimulus: load 0x400 after reset; sram_ready after 5 cycles with rdata 0x0000_BBBB_0000_AAAA.
- Response: ready=0 for 5 cycles, then out=0x0000AAAA with ready=1.
- Follow-up: load 0x404 is a same-cycle hit, out=0x0000BBBB.
REQ-017 Store hit:
- Stimulus: with 0x400 cached, store 0x12345678 to 0x400.
- Response: sram_w_en held until sram_ready; the next load of 0x400 hits and returns 0x12345678 with no sram_r_en.
REQ-018 Eviction:
- Stimulus: fill addresses 0x400, 0x600 and 0x800 (same index 0, different tags); before the 0x800 miss, the last access was 0x600.
- Response: 0x800 replaces the 0x400 way; a subsequent load of 0x400 misses and 0x600 hits.
REQ-019 Store miss:
- Stimulus: store to uncached 0xA00.
- Response: SRAM write only; a following load of 0xA00 misses.
REQ-020 Simultaneous MEM_R_EN and MEM_W_EN:
- Response: only sram_w_en asserts.
REQ-021 Reset mid-miss:
- Stimulus: assert rst 2 cycles into READ_MISS, then deassert.
- Response: ready=1 and sram_r_en=0 immediately; a stray sram_ready is ignored; the previously cached 0x400 now misses.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between the
// MEM stage and the SRAM controller; hits answer in the request cycle.
module cache_controller #(
  parameter int          SET_COUNT = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] out,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W  = $clog2(SET_COUNT);
  localparam int TAG_W  = 10;
  localparam int TAG_LO = 3 + IDX_W;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  function automatic logic [31:0] word_of(input logic [63:0] line, input logic sel);
    word_of = sel ? line[63:32] : line[31:0];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                             input logic [31:0] w);
    merge_word = sel ? {w, line[31:0]} : {line[63:32], w};
  endfunction

  state_t              state_r;
  logic                sram_r_en_r;
  logic                sram_w_en_r;

  logic [TAG_W-1:0]    tag0_r  [SET_COUNT];
  logic [TAG_W-1:0]    tag1_r  [SET_COUNT];
  logic [63:0]         line0_r [SET_COUNT];
  logic [63:0]         line1_r [SET_COUNT];
  logic [SET_COUNT-1:0] valid0_r;
  logic [SET_COUNT-1:0] valid1_r;
  logic [SET_COUNT-1:0] lru_r;

  logic [31:0]         addr_off_s;
  logic                addr_unused_s;
  logic                word_sel_s;
  logic [IDX_W-1:0]    idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic                hit0_s;
  logic                hit1_s;
  logic                hit_s;
  logic [63:0]         hit_line_s;
  logic                fill_way_s;
  logic                rd_req_s;
  logic                wr_req_s;
  logic                fill_s;
  logic                rd_hit_s;
  logic                wr_hit_s;
  logic                ready_s;
  logic [31:0]         out_s;

  assign addr_off_s    = ALU_Res - BASE_ADDR;
  assign addr_unused_s = ^{addr_off_s[31:TAG_HI+1], addr_off_s[1:0]};
  assign word_sel_s    = addr_off_s[2];
  assign idx_s         = addr_off_s[TAG_LO-1:3];
  assign tag_s         = addr_off_s[TAG_HI:TAG_LO];

  assign hit0_s     = valid0_r[idx_s] && (tag0_r[idx_s] == tag_s);
  assign hit1_s     = valid1_r[idx_s] && (tag1_r[idx_s] == tag_s);
  assign hit_s      = hit0_s || hit1_s;
  assign hit_line_s = hit1_s ? line1_r[idx_s] : line0_r[idx_s];

  // Fill prefers an empty way (way0 first) and otherwise evicts the LRU way.
  assign fill_way_s = !valid0_r[idx_s] ? 1'b0 :
                      !valid1_r[idx_s] ? 1'b1 : lru_r[idx_s];

  // A simultaneous load and store is handled as a store.
  assign rd_req_s = MEM_R_EN && !MEM_W_EN;
  assign wr_req_s = MEM_W_EN;

  assign fill_s   = !rst && (state_r == READ_MISS) && sram_ready;
  assign rd_hit_s = !rst && (state_r == IDLE) && rd_req_s && hit_s;
  assign wr_hit_s = !rst && (state_r == WRITE) && sram_ready && hit_s;

  // Valid and LRU bookkeeping; these are the only cache bits that need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_r <= '0;
      valid1_r <= '0;
      lru_r    <= '0;
    end else if (fill_s) begin
      if (fill_way_s) begin
        valid1_r[idx_s] <= 1'b1;
      end else begin
        valid0_r[idx_s] <= 1'b1;
      end
      lru_r[idx_s] <= ~fill_way_s;
    end else if (rd_hit_s || wr_hit_s) begin
      lru_r[idx_s] <= hit0_s;
    end
  end

  // Line and tag storage: miss fills and store-hit word merges.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      if (fill_way_s) begin
        line1_r[idx_s] <= sram_rdata;
        tag1_r[idx_s]  <= tag_s;
      end else begin
        line0_r[idx_s] <= sram_rdata;
        tag0_r[idx_s]  <= tag_s;
      end
    end else if (wr_hit_s) begin
      if (hit1_s) begin
        line1_r[idx_s] <= merge_word(line1_r[idx_s], word_sel_s, Val_Rm);
      end else begin
        line0_r[idx_s] <= merge_word(line0_r[idx_s], word_sel_s, Val_Rm);
      end
    end
  end

  // Controller FSM with registered SRAM request strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sram_r_en_r <= 1'b0;
      sram_w_en_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_req_s) begin
            state_r     <= WRITE;
            sram_w_en_r <= 1'b1;
          end else if (MEM_R_EN && !hit_s) begin
            state_r     <= READ_MISS;
            sram_r_en_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            state_r     <= IDLE;
            sram_r_en_r <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_r     <= IDLE;
            sram_w_en_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          sram_r_en_r <= 1'b0;
          sram_w_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline handshake: hits and SRAM completions answer in the same cycle.
  always_comb begin
    ready_s = 1'b1;
    out_s   = 32'd0;
    if (rst) begin
      ready_s = 1'b1;
      out_s   = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_req_s) begin
            ready_s = 1'b0;
          end else if (MEM_R_EN) begin
            if (hit_s) begin
              out_s = word_of(hit_line_s, word_sel_s);
            end else begin
              ready_s = 1'b0;
            end
          end else begin
            ready_s = 1'b1;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            out_s = word_of(sram_rdata, word_sel_s);
          end else begin
            ready_s = 1'b0;
          end
        end
        WRITE: begin
          ready_s = sram_ready;
        end
        default: begin
          ready_s = 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_s;
  assign out        = out_s;
  assign sram_r_en  = sram_r_en_r;
  assign sram_w_en  = sram_w_en_r;
  assign sram_addr  = ALU_Res;
  assign sram_wdata = Val_Rm;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed requests push expectations,
// a monitor pops them whenever a request completes, an SRAM model answers.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] out;
  logic        ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  cache_controller #(.SET_COUNT(64), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .out(out), .ready(ready),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] out;
    int          stall;
    int          rd;
    int          wr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sram_lat = 1;
  int   stray_seq = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // SRAM controller model: pulses sram_ready after sram_lat request cycles.
  initial begin
    int cnt = 0;
    int stray_done = 0;
    sram_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        sram_ready = 1'b0;
        cnt = 0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        cnt = 0;
      end else if (stray_seq != stray_done) begin
        stray_done = stray_seq;
        sram_ready = 1'b1;
      end else if (sram_r_en || sram_w_en) begin
        cnt++;
        if (cnt >= sram_lat) sram_ready = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: accumulates per-request activity and compares at completion.
  initial begin
    int   stall_c = 0;
    int   rd_c = 0;
    int   wr_c = 0;
    logic bad = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_c = 0; rd_c = 0; wr_c = 0; bad = 1'b0;
      end else if (MEM_R_EN || MEM_W_EN) begin
        if (sram_r_en) rd_c++;
        if (sram_w_en) wr_c++;
        if (sram_r_en && sram_w_en) bad = 1'b1;
        if ((sram_r_en || sram_w_en) && sram_addr !== ALU_Res) bad = 1'b1;
        if (sram_w_en && sram_wdata !== Val_Rm) bad = 1'b1;
        if (!ready) begin
          stall_c++;
          if (out !== 32'd0) bad = 1'b1;
        end else begin
          if (q.size() == 0) begin
            chk("unexpected_completion", 64'(q.size()), 64'd1);
          end else begin
            e = q.pop_front();
            chk({e.name, ".out"},   64'(out),     64'(e.out));
            chk({e.name, ".stall"}, 64'(stall_c), 64'(e.stall));
            chk({e.name, ".rd"},    64'(rd_c),    64'(e.rd));
            chk({e.name, ".wr"},    64'(wr_c),    64'(e.wr));
            chk({e.name, ".bus"},   64'(bad),     64'd0);
          end
          stall_c = 0; rd_c = 0; wr_c = 0; bad = 1'b0;
        end
      end
    end
  end

  task automatic req(input string name, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [63:0] rdata, input int lat, input logic [31:0] exp_out,
                     input int exp_stall, input int exp_rd, input int exp_wr);
    exp_t e;
    int   cyc;
    logic done;
    e.name = name; e.out = exp_out; e.stall = exp_stall; e.rd = exp_rd; e.wr = exp_wr;
    q.push_back(e);
    @(posedge clk);
    #1;
    ALU_Res = addr; Val_Rm = wdata; sram_rdata = rdata; sram_lat = lat;
    MEM_R_EN = rd; MEM_W_EN = wr;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      done = ready;
      cyc++;
    end
    if (!done) begin
      chk({name, ".timeout"}, 64'(cyc), 64'd0);
      void'(q.pop_back());
    end
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  task automatic load_miss(input string name, input logic [31:0] addr, input logic [63:0] rdata,
                           input int lat, input logic [31:0] exp_out);
    req(name, 1'b1, 1'b0, addr, 32'd0, rdata, lat, exp_out, lat, lat, 0);
  endtask

  task automatic load_hit(input string name, input logic [31:0] addr, input logic [31:0] exp_out);
    req(name, 1'b1, 1'b0, addr, 32'd0, 64'h0, 3, exp_out, 0, 0, 0);
  endtask

  task automatic store(input string name, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input int lat);
    req(name, rd, 1'b1, addr, data, 64'h0, lat, 32'd0, lat, 0, lat);
  endtask

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    ALU_Res = 32'd0; Val_Rm = 32'd0; sram_rdata = 64'd0;
    #12;
    chk("reset.ready", 64'(ready), 64'd1);
    chk("reset.out", 64'(out), 64'd0);
    chk("reset.sram_r_en", 64'(sram_r_en), 64'd0);
    chk("reset.sram_w_en", 64'(sram_w_en), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", 64'(ready), 64'd1);
    chk("idle.out", 64'(out), 64'd0);

    load_miss("cold_miss", 32'h400, 64'h0000_BBBB_0000_AAAA, 5, 32'h0000_AAAA);
    load_hit("hit_404", 32'h404, 32'h0000_BBBB);
    store("store_hit", 1'b0, 32'h400, 32'h1234_5678, 3);
    load_hit("hit_after_store", 32'h400, 32'h1234_5678);
    load_miss("miss_604", 32'h604, 64'h6666_6666_5555_5555, 2, 32'h6666_6666);
    load_miss("miss_800", 32'h800, 64'h8888_8888_7777_7777, 4, 32'h7777_7777);
    load_hit("hit_600", 32'h600, 32'h5555_5555);
    load_miss("evicted_400", 32'h400, 64'h4444_4444_3333_3333, 2, 32'h3333_3333);
    store("store_miss", 1'b0, 32'hA00, 32'hDEAD_BEEF, 2);
    load_miss("miss_a00", 32'hA00, 64'hAAAA_0002_AAAA_0001, 2, 32'hAAAA_0001);
    store("rd_wr_both", 1'b1, 32'h404, 32'hCAFE_F00D, 3);
    load_hit("hit_404_merged", 32'h404, 32'hCAFE_F00D);
    load_hit("hit_400_kept", 32'h400, 32'h3333_3333);
    load_miss("miss_set1", 32'h40C, 64'h0000_000C_0000_0008, 1, 32'h0000_000C);
    load_hit("hit_set1", 32'h408, 32'h0000_0008);

    // Abort a read miss with reset two cycles into READ_MISS.
    @(posedge clk); #1;
    ALU_Res = 32'hC00; MEM_R_EN = 1'b1; sram_lat = 100;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("abort.ready", 64'(ready), 64'd1);
    chk("abort.sram_r_en", 64'(sram_r_en), 64'd0);
    chk("abort.out", 64'(out), 64'd0);
    MEM_R_EN = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    stray_seq++;
    @(negedge clk);
    chk("stray.ready", 64'(ready), 64'd1);
    chk("stray.out", 64'(out), 64'd0);
    @(posedge clk); #3;
    chk("stray.sram_r_en", 64'(sram_r_en), 64'd0);
    chk("stray.sram_w_en", 64'(sram_w_en), 64'd0);
    load_miss("post_reset_400", 32'h400, 64'h0BAD_0002_0BAD_0001, 3, 32'h0BAD_0001);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
